count_pacer: RTL

COUNT_PACER -- requirements
Module: count_pacer

---
 rtl/count_pacer.sv | 76 +++++++
 1 files changed

// File: rtl/count_pacer.sv
// count_pacer: debounced run/pause and single-step control of a DIV-cycle tick pacer
// Ports: clk, reset (async, active-high); btn_run/btn_step raw bouncing buttons;
//   tick = one-cycle count-enable pulse; running = 1 in RUN, 0 in PAUSE.
module count_pacer #(
  parameter int DIV        = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter bit START_RUN  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_step,
  output logic tick,
  output logic running
);
  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] P_MAX = PW'(DIV - 1);
  localparam logic [DW-1:0] D_MAX = DW'(DEB_CYCLES - 1);
  typedef enum logic {RUN, PAUSE} state_t;
  state_t state, state_n;
  logic [PW-1:0] psc, psc_n;
  logic [1:0] s1, s2, press;
  logic tick_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {btn_step, btn_run};
      s2 <= s1;
    end
  // bit 0 is the run button, bit 1 the step button
  for (genvar b = 0; b < 2; b++) begin : g_deb
    logic [DW-1:0] cnt;
    logic lvl, p, flip;
    assign flip = (s2[b] != lvl) && (cnt == D_MAX);
    assign press[b] = p;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        cnt <= '0;
        lvl <= 1'b0;
        p   <= 1'b0;
      end else begin
        cnt <= (s2[b] == lvl || flip) ? '0 : cnt + DW'(1);
        lvl <= flip ? s2[b] : lvl;
        p   <= flip & s2[b];
      end
  end
  always_comb begin
    state_n = state;
    psc_n   = '0;
    tick_n  = 1'b0;
    if (state == RUN) begin
      // terminal count still ticks even when a run press leaves RUN
      tick_n  = psc == P_MAX;
      state_n = press[0] ? PAUSE : RUN;
      psc_n   = (press[0] || psc == P_MAX) ? '0 : psc + PW'(1);
    end else begin
      // run press wins over step; the ~tick guard keeps ticks from abutting
      state_n = press[0] ? RUN : PAUSE;
      tick_n  = press[1] & ~press[0] & ~tick;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= START_RUN ? RUN : PAUSE;
      psc   <= '0;
      tick  <= 1'b0;
    end else begin
      state <= state_n;
      psc   <= psc_n;
      tick  <= tick_n;
    end
  assign running = state == RUN;
endmodule
